// File: rtl/float_fir_pkg.sv
// Shared constants and state encoding for the float FIR tap feeder.
package float_fir_pkg;

  localparam int          TAPS_DEFAULT = 8;
  localparam logic [31:0] FLOAT_ZERO   = 32'h0000_0000;
  localparam logic [31:0] FLOAT_ONE    = 32'h3F80_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } feed_state_e;

endpackage

// File: rtl/float_fir_coef_ram.sv
// TAPS x 32 coefficient register file.
// Writes are synchronous and range-checked; reads are asynchronous.
module float_fir_coef_ram
  import float_fir_pkg::*;
#(
  parameter  int TAPS  = TAPS_DEFAULT,
  localparam int IDX_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [TAPS];
  logic        addr_ok;

  // When TAPS is not a power of two, the index field can encode unused slots.
  assign addr_ok = {{(32-IDX_W){1'b0}}, wr_addr} < 32'(TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= FLOAT_ZERO;
    end else if (we && addr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/float_fir_tap_feeder.sv
// Delay line plus issue FSM; streams (sample, coefficient) pairs to the multiplier.
// Every output is a flop, so operands for the next tap are looked up one cycle early.
module float_fir_tap_feeder
  import float_fir_pkg::*;
#(
  parameter  int TAPS  = TAPS_DEFAULT,
  localparam int IDX_W = $clog2(TAPS)
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [31:0]      i_X,
  input  logic             i_X_STB,
  output logic             o_X_ACK,
  input  logic             i_COEF_WE,
  input  logic [IDX_W-1:0] i_COEF_ADDR,
  input  logic [31:0]      i_COEF_DATA,
  output logic [31:0]      o_A,
  output logic [31:0]      o_B,
  output logic             o_AB_STB,
  input  logic             i_AB_ACK,
  output logic [IDX_W-1:0] o_TAP,
  output logic             o_LAST,
  output logic             o_BUSY
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  feed_state_e      state, state_nxt;
  logic [IDX_W-1:0] k, k_nxt;
  logic [31:0]      x [TAPS];
  logic [31:0]      coef_rd, coef_tap0;
  logic             last_tap, accept, advance;

  assign last_tap = (k == LAST_IDX);
  assign accept   = (state == IDLE) && i_X_STB;
  assign advance  = (state == ISSUE) && i_AB_ACK && !last_tap;

  // Writes are only honoured in IDLE so o_B cannot change under a pending strobe.
  float_fir_coef_ram #(.TAPS(TAPS)) u_coef (
    .clk     (i_CLK),
    .rst     (i_RST),
    .we      (i_COEF_WE && (state == IDLE)),
    .wr_addr (i_COEF_ADDR),
    .wr_data (i_COEF_DATA),
    .rd_addr (k_nxt),
    .rd_data (coef_rd)
  );

  // A tap-0 write landing on the accept edge must be seen by this very sample.
  assign coef_tap0 = (i_COEF_WE && (i_COEF_ADDR == '0)) ? i_COEF_DATA : coef_rd;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (i_X_STB) begin
          state_nxt = ISSUE;
          k_nxt     = '0;
        end
      end
      ISSUE: begin
        if (i_AB_ACK) begin
          if (last_tap) state_nxt = IDLE;
          else          k_nxt     = k + IDX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= IDLE;
      k        <= '0;
      o_X_ACK  <= 1'b1;
      o_AB_STB <= 1'b0;
      o_BUSY   <= 1'b0;
      o_A      <= FLOAT_ZERO;
      o_B      <= FLOAT_ZERO;
      o_TAP    <= '0;
      o_LAST   <= 1'b0;
      for (int i = 0; i < TAPS; i++) x[i] <= FLOAT_ZERO;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      o_X_ACK  <= (state_nxt == IDLE);
      o_AB_STB <= (state_nxt == ISSUE);
      o_BUSY   <= (state_nxt == ISSUE);
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0]   <= i_X;
        o_A    <= i_X;
        o_B    <= coef_tap0;
        o_TAP  <= '0;
        o_LAST <= 1'b0;
      end else if (advance) begin
        o_A    <= x[k_nxt];
        o_B    <= coef_rd;
        o_TAP  <= k_nxt;
        o_LAST <= (k_nxt == LAST_IDX);
      end
    end
  end

endmodule
